enable_checker: RTL and testbench

ENABLE_CHECKER -- requirements
Module: enable_checker

---
 rtl/enable_checker_pkg.sv | 7 +
 rtl/enable_checker_onehot_encoder.sv | 16 +
 rtl/enable_checker.sv | 98 +++++++++
 tb/tb_enable_checker.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enable_checker_pkg.sv
// enable_checker_pkg: shared FSM state type and default constants for the enable checker
package enable_checker_pkg;
   typedef enum logic [1:0] {ACQUIRE, LOCKED, FAULT} state_e;
   localparam int DEF_LOCK_CNT = 4;
   localparam int DEF_MISS_MAX = 2;
   localparam int ERR_W = 8;
endpackage

// File: rtl/enable_checker_onehot_encoder.sv
// onehot_encoder: vector to (lowest set bit + 1) index, plus a flag for more than one bit set
module onehot_encoder #(
   parameter int N = 15,
   parameter int W = 4
) (
   input  logic [N-1:0] vec,
   output logic [W-1:0] index,
   output logic         multi_hot
);
   // scan downwards so the lowest set bit is the last one written
   always_comb begin
      index = '0;
      for (int i = N - 1; i >= 0; i--) if (vec[i]) index = W'(i + 1);
   end
   assign multi_hot = |(vec & (vec - N'(1)));
endmodule

// File: rtl/enable_checker.sv
// enable_checker: tracks a scrambler's enable vector with a local LFSR and reports lock and faults
module enable_checker
   import enable_checker_pkg::*;
#(
   parameter int                  LFSR_WIDTH    = 16,
   parameter logic [LFSR_WIDTH:0] LFSR_POLY     = 17'b11010000000010001,
   parameter int                  LFSR_SEED     = 1,
   parameter int                  LFSR_USED_OUT = 4,
   parameter int                  OUT_NO        = 2**LFSR_USED_OUT - 1,
   parameter int                  LOCK_CNT      = DEF_LOCK_CNT,
   parameter int                  MISS_MAX      = DEF_MISS_MAX
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [OUT_NO-1:0]        enables_in,
   output logic [LFSR_USED_OUT-1:0] index_out,
   output logic                     match,
   output logic                     onehot_err,
   output logic                     locked,
   output logic                     fault,
   output logic [ERR_W-1:0]         err_count
);
   localparam int RUN_W  = $clog2(LOCK_CNT + 1);
   localparam int MISS_W = $clog2(MISS_MAX + 1);
   localparam int EW     = OUT_NO + 1;
   logic [LFSR_WIDTH-1:0]    lfsr_q, lfsr_d;
   logic [LFSR_USED_OUT-1:0] index_q, index_d;
   logic [EW-1:0]            exp_shift;
   logic [OUT_NO-1:0]        exp_vec;
   logic                     match_q, match_d, onehot_q, onehot_d;
   state_e                   state_q, state_d;
   logic [RUN_W-1:0]         run_q, run_d;
   logic [MISS_W-1:0]        miss_q, miss_d;
   logic [ERR_W-1:0]         err_q, err_d;

   onehot_encoder #(.N(OUT_NO), .W(LFSR_USED_OUT)) u_enc (
      .vec       (enables_in),
      .index     (index_d),
      .multi_hot (onehot_d)
   );

   // right-shifting Galois LFSR step and the enable vector it predicts (index 0 means no enable)
   always_comb begin
      lfsr_d    = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_POLY[LFSR_WIDTH:1] : '0);
      exp_shift = EW'(1) << lfsr_q[LFSR_USED_OUT-1:0];
      exp_vec   = exp_shift[OUT_NO:1];
      match_d   = (enables_in == exp_vec) && !onehot_d;
   end

   // lock/fault tracking driven by the registered match, so it trails the input by a cycle
   always_comb begin
      state_d = state_q;
      run_d   = '0;
      miss_d  = miss_q;
      err_d   = err_q;
      if (state_q == ACQUIRE) begin
         run_d = match_q ? run_q + RUN_W'(1) : '0;
         if (match_q && run_q == RUN_W'(LOCK_CNT - 1)) begin
            state_d = LOCKED;
            run_d   = '0;
         end
      end else if (state_q == LOCKED) begin
         miss_d = match_q ? '0 : miss_q + MISS_W'(1);
         err_d  = (match_q || err_q == '1) ? err_q : err_q + ERR_W'(1);
         if (!match_q && miss_q == MISS_W'(MISS_MAX - 1)) state_d = FAULT;
      end
   end

   // state registers; reset wins over every other update
   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr_q   <= LFSR_WIDTH'(LFSR_SEED);
         index_q  <= '0;
         match_q  <= 1'b0;
         onehot_q <= 1'b0;
         state_q  <= ACQUIRE;
         run_q    <= '0;
         miss_q   <= '0;
         err_q    <= '0;
      end else begin
         lfsr_q   <= lfsr_d;
         index_q  <= index_d;
         match_q  <= match_d;
         onehot_q <= onehot_d;
         state_q  <= state_d;
         run_q    <= run_d;
         miss_q   <= miss_d;
         err_q    <= err_d;
      end
   end

   assign index_out  = index_q;
   assign match      = match_q;
   assign onehot_err = onehot_q;
   assign locked     = (state_q == LOCKED);
   assign fault      = (state_q == FAULT);
   assign err_count  = err_q;
endmodule

// File: tb/tb_enable_checker.sv
// tb_enable_checker: directed scenarios against a bench-side scrambler for the enable checker
module tb_enable_checker;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [14:0] enables_in = '0;
   logic [3:0]  index_out;
   logic        match, onehot_err, locked, fault;
   logic [7:0]  err_count;
   int          errors = 0;
   int          checks = 0;
   logic [15:0] scr, chk;
   logic [15:0] scr_seed = 16'd1;
   logic        m_q, lk;
   int          run;

   // free-running clock
   always #5 clk = ~clk;

   enable_checker dut (
      .clk        (clk),
      .reset      (reset),
      .enables_in (enables_in),
      .index_out  (index_out),
      .match      (match),
      .onehot_err (onehot_err),
      .locked     (locked),
      .fault      (fault),
      .err_count  (err_count)
   );

   function automatic logic [15:0] step(input logic [15:0] s);
      logic fb;
      fb = s[0];
      s  = s >> 1;
      if (fb) s = s ^ 16'hD008;
      return s;
   endfunction

   function automatic logic [14:0] vec_of(input logic [15:0] s);
      logic [14:0] v;
      v = '0;
      if (s[3:0] != 4'd0) v[s[3:0] - 4'd1] = 1'b1;
      return v;
   endfunction

   task automatic tick();
      logic cur_match;
      cur_match = (enables_in == vec_of(chk));
      @(posedge clk);
      #1;
      if (reset) begin
         scr   = scr_seed;
         chk   = 16'd1;
         m_q   = 1'b0;
         run   = 0;
         lk    = 1'b0;
         reset = 1'b0;
      end else begin
         lk  = lk | (m_q && run == 3);
         run = m_q ? (run == 3 ? 0 : run + 1) : 0;
         m_q = cur_match;
         scr = step(scr);
         chk = step(chk);
      end
      enables_in = vec_of(scr);
   endtask

   task automatic pulse_reset(input logic [15:0] seed);
      scr_seed = seed;
      reset    = 1'b1;
      tick();
   endtask

   task automatic find_two_nonzero();
      int g;
      g = 0;
      while ((vec_of(scr) == '0 || vec_of(step(scr)) == '0) && g < 100) begin
         tick();
         g++;
      end
      checks++;
      if (g >= 100) begin errors++; $display("FAIL search_two: no usable cycles in %0d", g); end
   endtask

   task automatic test_reset();
      pulse_reset(16'd1);
      checks++;
      if ({index_out, match, onehot_err, locked, fault, err_count} !== 16'd0) begin
         errors++;
         $display("FAIL reset_outputs: idx=%0d m=%0d oh=%0d lk=%0d f=%0d err=%0d want all 0",
                  index_out, match, onehot_err, locked, fault, err_count);
      end
   endtask

   task automatic test_lock();
      logic [3:0] prev;
      logic [3:0] want_idx [1:4];
      want_idx = '{4'd1, 4'd8, 4'd4, 4'd2};
      pulse_reset(16'd1);
      for (int c = 1; c <= 4; c++) begin
         tick();
         checks++;
         if (index_out !== want_idx[c] || match !== 1'b1 || locked !== 1'b0) begin
            errors++;
            $display("FAIL lock_c%0d: idx=%0d m=%0d lk=%0d want idx=%0d m=1 lk=0", c, index_out, match, locked, want_idx[c]);
         end
      end
      tick();
      checks++;
      if (locked !== 1'b1) begin errors++; $display("FAIL lock_c5: locked=%0d want 1", locked); end
      for (int i = 0; i < 1000; i++) begin
         prev = scr[3:0];
         tick();
         checks++;
         if ({locked, err_count, index_out} !== {1'b1, 8'd0, prev}) begin
            errors++;
            $display("FAIL lock_run%0d: lk=%0d err=%0d idx=%0d want lk=1 err=0 idx=%0d", i, locked, err_count, index_out, prev);
         end
      end
   endtask

   task automatic test_single_miss();
      int g;
      g = 0;
      while (vec_of(scr) == '0 && g < 50) begin
         tick();
         g++;
      end
      checks++;
      if (g >= 50) begin errors++; $display("FAIL miss_search: no nonzero expected in %0d", g); end
      enables_in = '0;
      tick();
      checks++;
      if ({match, locked, err_count} !== {1'b0, 1'b1, 8'd0}) begin
         errors++;
         $display("FAIL miss_k1: m=%0d lk=%0d err=%0d want m=0 lk=1 err=0", match, locked, err_count);
      end
      tick();
      checks++;
      if ({match, locked, err_count} !== {1'b1, 1'b1, 8'd1}) begin
         errors++;
         $display("FAIL miss_k2: m=%0d lk=%0d err=%0d want m=1 lk=1 err=1", match, locked, err_count);
      end
   endtask

   task automatic test_fault();
      pulse_reset(16'd1);
      repeat (5) tick();
      checks++;
      if (locked !== 1'b1) begin errors++; $display("FAIL fault_prelock: locked=%0d want 1", locked); end
      find_two_nonzero();
      enables_in = '0;
      tick();
      enables_in = '0;
      tick();
      checks++;
      if ({match, locked, fault, err_count} !== {1'b0, 1'b1, 1'b0, 8'd1}) begin
         errors++;
         $display("FAIL fault_k2: m=%0d lk=%0d f=%0d err=%0d want m=0 lk=1 f=0 err=1", match, locked, fault, err_count);
      end
      tick();
      checks++;
      if ({locked, fault, err_count} !== {1'b0, 1'b1, 8'd2}) begin
         errors++;
         $display("FAIL fault_k3: lk=%0d f=%0d err=%0d want lk=0 f=1 err=2", locked, fault, err_count);
      end
      repeat (3) begin
         enables_in = 15'h7FFF;
         tick();
      end
      repeat (5) tick();
      checks++;
      if ({locked, fault, err_count} !== {1'b0, 1'b1, 8'd2}) begin
         errors++;
         $display("FAIL fault_sticky: lk=%0d f=%0d err=%0d want lk=0 f=1 err=2", locked, fault, err_count);
      end
   endtask

   task automatic test_multi_hot();
      pulse_reset(16'd1);
      repeat (3) tick();
      enables_in = 15'h0003;
      tick();
      checks++;
      if ({onehot_err, match, index_out} !== {1'b1, 1'b0, 4'd1}) begin
         errors++;
         $display("FAIL multi_c4: oh=%0d m=%0d idx=%0d want oh=1 m=0 idx=1", onehot_err, match, index_out);
      end
      tick();
      checks++;
      if ({onehot_err, match, locked} !== {1'b0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL multi_c5: oh=%0d m=%0d lk=%0d want oh=0 m=1 lk=0", onehot_err, match, locked);
      end
      repeat (3) tick();
      checks++;
      if (locked !== 1'b0) begin errors++; $display("FAIL multi_c8: locked=%0d want 0", locked); end
      tick();
      checks++;
      if (locked !== 1'b1) begin errors++; $display("FAIL multi_c9: locked=%0d want 1", locked); end
   endtask

   task automatic test_seed_mismatch();
      pulse_reset(16'd2);
      for (int i = 0; i < 500; i++) begin
         tick();
         checks++;
         if ({match, onehot_err, locked, err_count} !== {m_q, 1'b0, lk, 8'd0}) begin
            errors++;
            $display("FAIL seed_c%0d: m=%0d oh=%0d lk=%0d err=%0d want m=%0d oh=0 lk=%0d err=0",
                     i, match, onehot_err, locked, err_count, m_q, lk);
         end
         if (lk) break;
      end
   endtask

   task automatic test_saturate();
      int g;
      pulse_reset(16'd1);
      repeat (5) tick();
      for (int i = 1; i <= 300; i++) begin
         g = 0;
         while (vec_of(scr) == '0 && g < 50) begin
            tick();
            g++;
         end
         if (g >= 50) begin
            checks++;
            errors++;
            $display("FAIL sat_search%0d: no nonzero expected in %0d", i, g);
         end
         enables_in = '0;
         tick();
         tick();
         if (i == 1 || i == 100 || i == 254 || i == 255 || i == 256 || i == 300) begin
            checks++;
            if ({locked, fault, err_count} !== {1'b1, 1'b0, (i > 255 ? 8'd255 : 8'(i))}) begin
               errors++;
               $display("FAIL sat_%0d: lk=%0d f=%0d err=%0d want lk=1 f=0 err=%0d",
                        i, locked, fault, err_count, (i > 255 ? 255 : i));
            end
         end
      end
   endtask

   task automatic test_reset_from_fault();
      pulse_reset(16'd1);
      repeat (5) tick();
      find_two_nonzero();
      enables_in = '0;
      tick();
      enables_in = '0;
      tick();
      tick();
      checks++;
      if (fault !== 1'b1) begin errors++; $display("FAIL rf_fault: fault=%0d want 1", fault); end
      pulse_reset(16'd1);
      checks++;
      if ({index_out, match, onehot_err, locked, fault, err_count} !== 16'd0) begin
         errors++;
         $display("FAIL rf_reset: idx=%0d m=%0d oh=%0d lk=%0d f=%0d err=%0d want all 0",
                  index_out, match, onehot_err, locked, fault, err_count);
      end
      repeat (4) tick();
      checks++;
      if (locked !== 1'b0) begin errors++; $display("FAIL rf_c4: locked=%0d want 0", locked); end
      tick();
      checks++;
      if ({locked, fault} !== 2'b10) begin
         errors++;
         $display("FAIL rf_c5: lk=%0d f=%0d want lk=1 f=0", locked, fault);
      end
   endtask

   // scenario sequence
   initial begin
      test_reset();
      test_lock();
      test_single_miss();
      test_fault();
      test_multi_hot();
      test_seed_mismatch();
      test_saturate();
      test_reset_from_fault();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // runaway guard
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end
endmodule
